serial_add_sub: RTL and testbench

//  Digit-serial integer adder/subtractor for the FPU basics library; successor to the

---
 rtl/serial_add_sub_if.sv | 26 ++
 rtl/serial_add_sub.sv | 109 ++++++++++
 tb/tb_serial_add_sub.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master issues operations; the slave (the datapath) returns results and status flags.
interface serial_add_sub_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic            op;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] res;
    logic            cout;
    logic            ovf;
    logic            zero;

    modport master (
        output start, op, a, b,
        input  busy, done, res, cout, ovf, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, res, cout, ovf, zero
    );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial integer adder/subtractor: DIGIT bits per cycle, LSB digit first, one
// DIGIT-wide carry chain plus a carry flop. Subtraction is a + ~b + 1.
module serial_add_sub #(
    parameter int SIZE  = 32,
    parameter int DIGIT = 8     // must divide SIZE
) (
    input logic             clk,
    input logic             rst_n,
    serial_add_sub_if.slave bus
);
    localparam int N  = SIZE / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg;
    logic [SIZE-1:0] a_reg;
    logic [SIZE-1:0] b_reg;
    logic [SIZE-1:0] part_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [SIZE-1:0] res_reg;
    logic            cout_reg;
    logic            ovf_reg;
    logic            zero_reg;

    logic [DIGIT-1:0] a_dig [N];
    logic [DIGIT-1:0] b_dig [N];
    logic [DIGIT-1:0] a_cur;
    logic [DIGIT-1:0] b_cur;
    logic [DIGIT:0]   sum_next;
    logic [SIZE-1:0]  part_next;
    logic             last_digit;
    logic             ovf_next;

    // Operands stay parallel; the active digit is selected by the counter, and the
    // partial result is written one digit at a time so res only changes at done.
    for (genvar gi = 0; gi < N; gi++) begin : g_digit
        assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
        assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
        assign part_next[gi*DIGIT +: DIGIT] = (cnt_reg == CW'(gi)) ? sum_next[DIGIT-1:0]
                                                                     : part_reg[gi*DIGIT +: DIGIT];
    end

    assign a_cur      = a_dig[cnt_reg];
    assign b_cur      = b_dig[cnt_reg];
    assign sum_next   = {1'b0, a_cur} + {1'b0, b_cur} + {{DIGIT{1'b0}}, carry_reg};
    assign last_digit = (cnt_reg == CW'(N - 1));
    // b_reg already holds the (possibly inverted) second operand, so this covers add and sub.
    assign ovf_next   = (a_reg[SIZE-1] == b_reg[SIZE-1]) && (part_next[SIZE-1] != a_reg[SIZE-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            part_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            res_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b ^ {SIZE{bus.op}};
                        carry_reg <= bus.op;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    part_reg  <= part_next;
                    carry_reg <= sum_next[DIGIT];
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_digit) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        res_reg   <= part_next;
                        cout_reg  <= sum_next[DIGIT];
                        ovf_reg   <= ovf_next;
                        zero_reg  <= ~|part_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.res  = res_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.zero = zero_reg;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed checks on the DIGIT=8 instance, then random
// operations run on DIGIT=8, DIGIT=1 and DIGIT=32 instances side by side.
module tb_serial_add_sub;
    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        multi_en;

    int checks = 0;
    int failures = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q32[$];

    always #5 clk = ~clk;

    serial_add_sub_if #(.SIZE(32)) if8 ();
    serial_add_sub_if #(.SIZE(32)) if1 ();
    serial_add_sub_if #(.SIZE(32)) if32 ();

    assign if8.start  = start;
    assign if8.op     = op;
    assign if8.a      = a;
    assign if8.b      = b;
    assign if1.start  = start & multi_en;
    assign if1.op     = op;
    assign if1.a      = a;
    assign if1.b      = b;
    assign if32.start = start & multi_en;
    assign if32.op    = op;
    assign if32.a     = a;
    assign if32.b     = b;

    serial_add_sub #(.SIZE(32), .DIGIT(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_add_sub #(.SIZE(32), .DIGIT(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_add_sub #(.SIZE(32), .DIGIT(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o, input logic z);
        exp_t e;
        e.res = r; e.cout = c; e.ovf = o; e.zero = z;
        return e;
    endfunction

    // Golden model from integer arithmetic: signed range check for ovf, unsigned compare for borrow.
    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      r;
        logic [32:0] t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = o ? (sx - sy) : (sx + sy);
        t  = {1'b0, x} + {1'b0, y};
        e.res  = o ? (x - y) : (x + y);
        e.cout = o ? (x >= y) : t[32];
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Call at a negedge: drives a request, waits through the accepting edge.
    task automatic issue8(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input exp_t e, input string tag);
        op = o; a = x; b = y; start = 1'b1;
        q8.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, 64'(if8.busy), 64'd1);
        chk({tag, "_done_low"}, 64'(if8.done), 64'd0);
    endtask

    // Returns at the negedge of the done cycle; 'skipped' negedges were already consumed.
    task automatic wait_done8(input string tag, input int skipped);
        int   lat;
        int   nbusy;
        exp_t got;
        exp_t want;
        lat = -1;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if8.done) begin
                lat = i;
                break;
            end
            nbusy += int'(if8.busy);
        end
        chk({tag, "_latency"}, 64'(lat), 64'(4 - skipped));
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(4 - skipped));
        chk({tag, "_pending"}, 64'(q8.size()), 64'd1);
        if (q8.size() > 0) begin
            want = q8.pop_front();
            got  = {if8.res, if8.cout, if8.ovf, if8.zero};
            chk({tag, "_result"}, 64'(got), 64'(want));
            $display("txn %s res=%08h cout=%0b ovf=%0b zero=%0b", tag, if8.res, if8.cout, if8.ovf, if8.zero);
        end
    endtask

    initial begin
        logic        ro;
        logic [31:0] rx;
        logic [31:0] ry;
        exp_t        e;
        exp_t        g8;
        exp_t        g1;
        exp_t        g32;
        exp_t        w;
        int          l8;
        int          l1;
        int          l32;
        int          ndone;

        start = 1'b0; op = 1'b0; a = '0; b = '0; multi_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(if8.busy), 64'd0);
        chk("reset_done", 64'(if8.done), 64'd0);
        chk("reset_res", 64'(if8.res), 64'd0);
        chk("reset_flags", 64'({if8.cout, if8.ovf, if8.zero}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add, then done is a single pulse and results hold afterwards
        issue8(1'b0, 32'h0000_00FF, 32'h0000_0001, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0), "t1_add");
        wait_done8("t1_add", 0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(if8.done), 64'd0);
        repeat (2) @(negedge clk);
        chk("t1_hold_res", 64'(if8.res), 64'h100);

        issue8(1'b1, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), "t2_sub_borrow");
        wait_done8("t2_sub_borrow", 0);
        @(negedge clk);
        issue8(1'b0, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0), "t3_add_ovf");
        wait_done8("t3_add_ovf", 0);
        @(negedge clk);
        issue8(1'b1, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), "t3_sub_ovf");
        wait_done8("t3_sub_ovf", 0);
        @(negedge clk);
        issue8(1'b1, 32'h1234_5678, 32'h1234_5678, mk(32'h0, 1'b1, 1'b0, 1'b1), "t4_sub_zero");
        wait_done8("t4_sub_zero", 0);
        @(negedge clk);
        issue8(1'b0, 32'hFFFF_FFFF, 32'd1, mk(32'h0, 1'b1, 1'b0, 1'b1), "t4_add_wrap");
        wait_done8("t4_add_wrap", 0);
        @(negedge clk);

        // start with new operands during RUN must be ignored
        issue8(1'b0, 32'h1111_1111, 32'h2222_2222, mk(32'h3333_3333, 1'b0, 1'b0, 1'b0), "t5_ignore");
        start = 1'b1; op = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0005;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done8("t5_ignore", 2);
        @(negedge clk);
        chk("t5_ignore_no_restart", 64'(if8.busy), 64'd0);
        @(negedge clk);

        // Back-to-back: second start presented in the done cycle
        issue8(1'b1, 32'h0000_0010, 32'h0000_0003, mk(32'h0000_000D, 1'b1, 1'b0, 1'b0), "t5_b2b_a");
        wait_done8("t5_b2b_a", 0);
        issue8(1'b0, 32'h4000_0000, 32'h4000_0000, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0), "t5_b2b_b");
        wait_done8("t5_b2b_b", 0);
        @(negedge clk);

        // Reset mid-operation: outputs clear at once, no done pulse afterwards
        issue8(1'b0, 32'd1, 32'd1, mk(32'd2, 1'b0, 1'b0, 1'b0), "t5_abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_abort_busy", 64'(if8.busy), 64'd0);
        chk("t5_abort_res", 64'(if8.res), 64'd0);
        chk("t5_abort_flags", 64'({if8.done, if8.cout, if8.ovf, if8.zero}), 64'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ndone += int'(if8.done);
        end
        chk("t5_abort_no_done", 64'(ndone), 64'd0);

        // Random operations on all three digit widths
        multi_en = 1'b1;
        for (int t = 0; t < 100; t++) begin
            ro = 1'($urandom_range(0, 1));
            rx = pick();
            ry = pick();
            e  = model(ro, rx, ry);
            op = ro; a = rx; b = ry; start = 1'b1;
            q8.push_back(e); q1.push_back(e); q32.push_back(e);
            @(posedge clk); #1;
            start = 1'b0;
            l8 = -1; l1 = -1; l32 = -1;
            g8 = 'x; g1 = 'x; g32 = 'x;
            for (int i = 0; i < 40 && !(l8 >= 0 && l1 >= 0 && l32 >= 0); i++) begin
                @(negedge clk);
                if (if8.done)  begin l8  = i; g8  = {if8.res,  if8.cout,  if8.ovf,  if8.zero};  end
                if (if1.done)  begin l1  = i; g1  = {if1.res,  if1.cout,  if1.ovf,  if1.zero};  end
                if (if32.done) begin l32 = i; g32 = {if32.res, if32.cout, if32.ovf, if32.zero}; end
            end
            chk("rnd_lat_d8", 64'(l8), 64'd4);
            chk("rnd_lat_d1", 64'(l1), 64'd32);
            chk("rnd_lat_d32", 64'(l32), 64'd1);
            if (q8.size() > 0)  begin w = q8.pop_front();  chk("rnd_res_d8", 64'(g8), 64'(w));   end
            if (q1.size() > 0)  begin w = q1.pop_front();  chk("rnd_res_d1", 64'(g1), 64'(w));   end
            if (q32.size() > 0) begin w = q32.pop_front(); chk("rnd_res_d32", 64'(g32), 64'(w)); end
            $display("csv,%0d,%0b,%08h,%08h,%08h,%0b,%0b,%0b", t, ro, rx, ry, g8.res, g8.cout, g8.ovf, g8.zero);
        end
        chk("end_queue_d8", 64'(q8.size()), 64'd0);
        chk("end_queue_d1", 64'(q1.size()), 64'd0);
        chk("end_queue_d32", 64'(q32.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
